// File: rtl/prmcu_uart_pkg.sv
// rtl/prmcu_uart_pkg.sv - shared types and constants for the prmcu UART blocks
package prmcu_uart_pkg;
  typedef enum logic [1:0] {NONE = 2'b00, EVEN = 2'b01, ODD = 2'b10} parity_mode_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_t;
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;
endpackage

// File: rtl/prmcu_uart_baud_tick.sv
// rtl/prmcu_uart_baud_tick.sv - prescaler producing a one-clk tick every clk_div_i+1 clocks
module prmcu_uart_baud_tick
  import prmcu_uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div_i,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divider lowered mid-count still wraps promptly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= clk_div_i) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/prmcu_uart_rx_os.sv
// rtl/prmcu_uart_rx_os.sv - oversampling UART receiver with majority vote, parity, break and overrun
module prmcu_uart_rx_os
  import prmcu_uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_W         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_en,
  input  logic [DIV_W-1:0]                   clk_div_i,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] n_data_bits_i,
  input  logic [1:0]                         parity_mode_i,
  input  logic                               n_stop_bits_i,
  input  logic                               rx_i,
  output logic [MAX_DATA_BITS-1:0]           out_dat_o,
  output logic [2:0]                         out_err_o,
  output logic                               out_vld_o,
  input  logic                               out_rdy_i,
  output logic                               overrun_o,
  output logic                               busy_o
);
  localparam int NW = $clog2(MAX_DATA_BITS + 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_S0   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_S1   = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] OS_VOTE = OW'(OVERSAMPLE / 2 + 1);

  logic                     rx_meta, rx, tick;
  rx_state_t                state;
  logic [OW-1:0]            os_cnt;
  logic [NW-1:0]            bit_cnt, n_data, n_clamped;
  parity_mode_t             par_mode, par_sel;
  logic                     two_stop, stop_second;
  logic                     s0, s1, vote, par_exp;
  logic [MAX_DATA_BITS-1:0] data;
  logic                     par_bit, par_err, frm_err;
  logic                     done, is_break;
  logic [2:0]               done_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx      <= rx_meta;
    end
  end

  prmcu_uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (rx_en),
    .clk_div_i (clk_div_i),
    .tick      (tick)
  );

  always_comb begin
    n_clamped = n_data_bits_i;
    if (n_data_bits_i < NW'(5))
      n_clamped = NW'(5);
    else if (n_data_bits_i > NW'(MAX_DATA_BITS))
      n_clamped = NW'(MAX_DATA_BITS);
    case (parity_mode_i)
      2'b01:   par_sel = EVEN;
      2'b10:   par_sel = ODD;
      default: par_sel = NONE;
    endcase
  end

  // third sample is the live synchronised value at the resolve tick
  assign vote     = (s0 & s1) | (s0 & rx) | (s1 & rx);
  assign par_exp  = (par_mode == ODD) ? ~(^data) : (^data);
  assign done     = rx_en && tick && (state == STOP) && (os_cnt == OS_VOTE) &&
                    (!two_stop || stop_second);
  assign is_break = !vote && (data == '0) && !((par_mode != NONE) && par_bit);
  assign busy_o   = (state != IDLE);

  always_comb begin
    done_err          = '0;
    done_err[ERR_PAR] = par_err;
    done_err[ERR_FRM] = frm_err | ~vote;
    done_err[ERR_BRK] = is_break;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      n_data      <= NW'(5);
      par_mode    <= NONE;
      two_stop    <= 1'b0;
      stop_second <= 1'b0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      data        <= '0;
      par_bit     <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
    end else if (!rx_en) begin
      state <= IDLE;
    end else if (tick) begin
      if (state inside {START, DATA, PARITY, STOP}) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (os_cnt == OS_S0) s0 <= rx;
        if (os_cnt == OS_S1) s1 <= rx;
      end
      case (state)
        IDLE: if (!rx) begin
          state       <= START;
          os_cnt      <= '0;
          n_data      <= n_clamped;
          par_mode    <= par_sel;
          two_stop    <= n_stop_bits_i;
          stop_second <= 1'b0;
          data        <= '0;
          par_bit     <= 1'b0;
          par_err     <= 1'b0;
          frm_err     <= 1'b0;
        end
        START: begin
          if (os_cnt == OS_VOTE && vote) state <= IDLE;
          else if (os_cnt == OS_LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (os_cnt == OS_VOTE) data <= data | (MAX_DATA_BITS'(vote) << bit_cnt);
          if (os_cnt == OS_LAST) begin
            if (bit_cnt == n_data - NW'(1)) state <= (par_mode == NONE) ? STOP : PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (os_cnt == OS_VOTE) begin
            par_bit <= vote;
            par_err <= (vote != par_exp);
          end
          if (os_cnt == OS_LAST) state <= STOP;
        end
        STOP: begin
          if (os_cnt == OS_VOTE) begin
            if (!two_stop || stop_second) state <= is_break ? BRK : IDLE;
            else if (!vote) frm_err <= 1'b1;
          end else if (os_cnt == OS_LAST) begin
            stop_second <= 1'b1;
          end
        end
        BRK: if (rx) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // single-entry holding register; a full register without ready drops the new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat_o <= '0;
      out_err_o <= '0;
      out_vld_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done) begin
        if (!out_vld_o || out_rdy_i) begin
          out_dat_o <= data;
          out_err_o <= done_err;
          out_vld_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prmcu_uart_rx_os.sv
// tb/tb_prmcu_uart_rx_os.sv - self-checking bench for prmcu_uart_rx_os
module tb_prmcu_uart_rx_os;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b0;
  logic [15:0] clk_div = 16'd4;
  logic [3:0]  n_bits = 4'd8;
  logic [1:0]  par_mode = 2'b00;
  logic        n_stop = 1'b0;
  logic        rx_line = 1'b1;
  logic        out_rdy = 1'b1;
  logic [8:0]  out_dat;
  logic [2:0]  out_err;
  logic        out_vld, overrun, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bit_clk = 80;
  int ovr_cnt = 0;
  int rd = 0;
  logic [8:0] q_dat[$];
  logic [2:0] q_err[$];
  int         q_cyc[$];

  prmcu_uart_rx_os dut (
    .clk           (clk),
    .rst           (rst),
    .rx_en         (rx_en),
    .clk_div_i     (clk_div),
    .n_data_bits_i (n_bits),
    .parity_mode_i (par_mode),
    .n_stop_bits_i (n_stop),
    .rx_i          (rx_line),
    .out_dat_o     (out_dat),
    .out_err_o     (out_err),
    .out_vld_o     (out_vld),
    .out_rdy_i     (out_rdy),
    .overrun_o     (overrun),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld && out_rdy) begin
        q_dat.push_back(out_dat);
        q_err.push_back(out_err);
        q_cyc.push_back(cyc);
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  function automatic int clampn(input int nb);
    return (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
  endfunction

  // expected {err, dat} derived from the frame as sent on the wire
  function automatic logic [11:0] model(input logic [8:0] val, input int nb, input int pm,
                                        input int ns, input bit flip, input bit bad_first,
                                        input bit bad_last);
    int n;
    logic [8:0] d;
    logic pen, pbit, pe, fe, brk;
    n    = clampn(nb);
    d    = val & 9'((1 << n) - 1);
    pen  = (pm == 1 || pm == 2);
    pbit = ((pm == 2) ? ~(^d) : (^d)) ^ flip;
    pe   = pen && flip;
    fe   = bad_last || (ns == 2 && bad_first);
    brk  = (d == 9'd0) && !(pen && pbit) && bad_last;
    return {brk, fe | brk, pe, d};
  endfunction

  task automatic set_cfg(input int nb, input int pm, input int ns, input int div);
    n_bits   = 4'(nb);
    par_mode = 2'(pm);
    n_stop   = (ns == 2);
    clk_div  = 16'(div);
    bit_clk  = 16 * (div + 1);
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (bit_clk) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    rx_line = 1'b1;
    repeat (nbits * bit_clk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] val, input int nb, input int pm, input int ns,
                            input bit flip, input bit bad_first, input bit bad_last);
    int n;
    logic [8:0] d;
    n = clampn(nb);
    d = val & 9'((1 << n) - 1);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (pm == 1 || pm == 2) drive_bit(((pm == 2) ? ~(^d) : (^d)) ^ flip);
    if (ns == 2) drive_bit(!bad_first);
    drive_bit(!bad_last);
  endtask

  task automatic test_reset();
    checks++;
    if ({out_dat, out_err, out_vld, overrun, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", {out_dat, out_err, out_vld, overrun, busy});
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({out_vld, busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: got vld/busy=%b, want 00", {out_vld, busy});
    end
  endtask

  task automatic test_8n1();
    int t0;
    set_cfg(8, 0, 1, 4);
    t0 = cyc;
    send_frame(9'h0A5, 8, 0, 1, 0, 0, 0);
    idle(1);
    checks++;
    if (q_dat.size() != rd + 1) begin
      errors++;
      $display("FAIL 8n1_count: got %0d words, want 1", q_dat.size() - rd);
    end
    if (q_dat.size() > rd) begin
      checks++;
      if ({q_err[rd], q_dat[rd]} !== {3'b000, 9'h0A5}) begin
        errors++;
        $display("FAIL 8n1_word: got err=%b dat=%h, want err=000 dat=0a5", q_err[rd], q_dat[rd]);
      end
      checks++;
      if (q_cyc[rd] - t0 < 720 || q_cyc[rd] - t0 > 800) begin
        errors++;
        $display("FAIL 8n1_latency: got %0d clk, want 720..800", q_cyc[rd] - t0);
      end
    end
    rd = q_dat.size();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_vld_drop: got vld=%b, want 0", out_vld);
    end
  endtask

  task automatic test_7e1();
    logic [11:0] want [2];
    want[0] = {3'b000, 9'h035};
    want[1] = {3'b001, 9'h035};
    set_cfg(7, 1, 1, 4);
    for (int k = 0; k < 2; k++) begin
      send_frame(9'h035, 7, 1, 1, k[0], 0, 0);
      idle(1);
      checks++;
      if (q_dat.size() <= rd) begin
        errors++;
        $display("FAIL 7e1_word%0d: got no word, want err=%b dat=%h", k, want[k][11:9], want[k][8:0]);
      end else begin
        if ({q_err[rd], q_dat[rd]} !== want[k]) begin
          errors++;
          $display("FAIL 7e1_word%0d: got err=%b dat=%h, want err=%b dat=%h",
                   k, q_err[rd], q_dat[rd], want[k][11:9], want[k][8:0]);
        end
        rd++;
      end
    end
  endtask

  task automatic test_9bit_2stop();
    set_cfg(9, 0, 2, 4);
    send_frame(9'h1FF, 9, 0, 2, 0, 0, 1);
    idle(1);
    checks++;
    if (q_dat.size() <= rd) begin
      errors++;
      $display("FAIL 9b2s_word: got no word, want err=010 dat=1ff");
    end else begin
      if ({q_err[rd], q_dat[rd]} !== {3'b010, 9'h1FF}) begin
        errors++;
        $display("FAIL 9b2s_word: got err=%b dat=%h, want err=010 dat=1ff", q_err[rd], q_dat[rd]);
      end
      rd++;
    end
  endtask

  task automatic test_glitch();
    set_cfg(8, 0, 1, 4);
    rx_line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (85) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got busy=%b, want 0", busy);
    end
    idle(1);
    checks++;
    if (q_dat.size() != rd) begin
      errors++;
      $display("FAIL glitch_word: got %0d words, want 0", q_dat.size() - rd);
    end
    rd = q_dat.size();
  endtask

  task automatic test_break();
    set_cfg(8, 0, 1, 4);
    rx_line = 1'b0;
    repeat (20 * bit_clk) @(posedge clk);
    #1;
    checks++;
    if (q_dat.size() != rd + 1) begin
      errors++;
      $display("FAIL break_count: got %0d words, want 1", q_dat.size() - rd);
    end
    if (q_dat.size() > rd) begin
      checks++;
      if ({q_err[rd], q_dat[rd]} !== {3'b110, 9'h000}) begin
        errors++;
        $display("FAIL break_word: got err=%b dat=%h, want err=110 dat=000", q_err[rd], q_dat[rd]);
      end
    end
    rd = q_dat.size();
    idle(2);
    send_frame(9'h03C, 8, 0, 1, 0, 0, 0);
    idle(1);
    checks++;
    if (q_dat.size() != rd + 1 || q_dat.size() == 0) begin
      errors++;
      $display("FAIL break_recover: got %0d words, want 1", q_dat.size() - rd);
    end else if ({q_err[rd], q_dat[rd]} !== {3'b000, 9'h03C}) begin
      errors++;
      $display("FAIL break_recover: got err=%b dat=%h, want err=000 dat=03c", q_err[rd], q_dat[rd]);
    end
    rd = q_dat.size();
  endtask

  task automatic test_overrun();
    int ovr0;
    set_cfg(8, 0, 1, 4);
    out_rdy = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(9'h011, 8, 0, 1, 0, 0, 0);
    idle(2);
    send_frame(9'h022, 8, 0, 1, 0, 0, 0);
    idle(2);
    checks++;
    if ({out_vld, out_dat} !== {1'b1, 9'h011}) begin
      errors++;
      $display("FAIL overrun_hold: got vld=%b dat=%h, want vld=1 dat=011", out_vld, out_dat);
    end
    checks++;
    if (ovr_cnt - ovr0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses, want 1", ovr_cnt - ovr0);
    end
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pop_vld: got vld=%b, want 0", out_vld);
    end
    checks++;
    if (q_dat.size() != rd + 1 || q_dat.size() == 0) begin
      errors++;
      $display("FAIL overrun_pop: got %0d words, want 1", q_dat.size() - rd);
    end else if (q_dat[rd] !== 9'h011) begin
      errors++;
      $display("FAIL overrun_pop: got dat=%h, want 011", q_dat[rd]);
    end
    rd = q_dat.size();
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    set_cfg(8, 0, 1, 4);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_en   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b, want 0", busy);
    end
    rx_en = 1'b1;
    idle(12);
    checks++;
    if (q_dat.size() != rd) begin
      errors++;
      $display("FAIL abort_word: got %0d words, want 0", q_dat.size() - rd);
    end
    rd = q_dat.size();
  endtask

  task automatic test_clamp();
    int nbs [2];
    logic [8:0] vals [2];
    logic [11:0] exp;
    nbs[0] = 3;  vals[0] = 9'h1F5;
    nbs[1] = 15; vals[1] = 9'h1AB;
    for (int k = 0; k < 2; k++) begin
      set_cfg(nbs[k], 0, 1, 4);
      send_frame(vals[k], nbs[k], 0, 1, 0, 0, 0);
      idle(1);
      exp = model(vals[k], nbs[k], 0, 1, 0, 0, 0);
      checks++;
      if (q_dat.size() <= rd) begin
        errors++;
        $display("FAIL clamp_n%0d: got no word, want dat=%h", nbs[k], exp[8:0]);
      end else begin
        if ({q_err[rd], q_dat[rd]} !== exp) begin
          errors++;
          $display("FAIL clamp_n%0d: got err=%b dat=%h, want err=%b dat=%h",
                   nbs[k], q_err[rd], q_dat[rd], exp[11:9], exp[8:0]);
        end
        rd++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals [2];
    vals[0] = 9'h05A;
    vals[1] = 9'h0C3;
    set_cfg(8, 0, 1, 4);
    send_frame(vals[0], 8, 0, 1, 0, 0, 0);
    send_frame(vals[1], 8, 0, 1, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q_dat.size() <= rd) begin
        errors++;
        $display("FAIL b2b_word%0d: got no word, want dat=%h", k, vals[k]);
      end else begin
        if ({q_err[rd], q_dat[rd]} !== {3'b000, vals[k]}) begin
          errors++;
          $display("FAIL b2b_word%0d: got err=%b dat=%h, want err=000 dat=%h",
                   k, q_err[rd], q_dat[rd], vals[k]);
        end
        rd++;
      end
    end
  endtask

  task automatic test_random();
    int nb, pm, ns, div;
    bit flip, bad_first, bad_last;
    logic [8:0] val;
    logic [11:0] exp;
    for (int k = 0; k < 10; k++) begin
      div       = 2 * $urandom_range(0, 2);
      nb        = $urandom_range(3, 11);
      pm        = $urandom_range(0, 3);
      ns        = $urandom_range(1, 2);
      val       = 9'($urandom);
      flip      = ($urandom_range(0, 3) == 0);
      bad_first = ($urandom_range(0, 4) == 0);
      bad_last  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) val = 9'd0;
      set_cfg(nb, pm, ns, div);
      idle(1);
      send_frame(val, nb, pm, ns, flip, bad_first, bad_last);
      idle(2);
      exp = model(val, nb, pm, ns, flip, bad_first, bad_last);
      checks++;
      if (q_dat.size() != rd + 1 || q_dat.size() == 0) begin
        errors++;
        $display("FAIL random%0d: got %0d words, want 1 (nb=%0d pm=%0d ns=%0d div=%0d)",
                 k, q_dat.size() - rd, nb, pm, ns, div);
      end else if ({q_err[rd], q_dat[rd]} !== exp) begin
        errors++;
        $display("FAIL random%0d: got err=%b dat=%h, want err=%b dat=%h (nb=%0d pm=%0d ns=%0d div=%0d)",
                 k, q_err[rd], q_dat[rd], exp[11:9], exp[8:0], nb, pm, ns, div);
      end
      rd = q_dat.size();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rx_en = 1'b1;
    idle(1);
    test_8n1();
    test_7e1();
    test_9bit_2stop();
    test_glitch();
    test_break();
    test_overrun();
    test_abort();
    test_clamp();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
